// File: rtl/edge_period_meter.sv
// edge_period_meter: measures the rise-to-rise interval of an asynchronous
// pulse train in clock cycles. It reports each new interval with a one-cycle
// strobe, counts valid measurements (mod 16) for an LED display, and raises a
// sticky timeout flag when no rise arrives within TIMEOUT_CYCLES.
`timescale 1ns/1ps

module edge_period_meter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd24000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        io_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        timeout,
    output logic [3:0]  io_out
);

    // Last count value that is still inside the measurable window.
    localparam logic [31:0] LIMIT = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        s1_reg;
    logic        s2_reg;
    logic        prev_reg;
    logic        rise;
    logic        at_limit;

    // Action decodes produced by the FSM output logic.
    logic        do_arm;
    logic        do_measure;
    logic        do_timeout;

    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;
    logic [31:0] period_reg;
    logic [31:0] period_next;
    logic        valid_reg;
    logic        valid_next;
    logic        timeout_reg;
    logic        timeout_next;
    logic [3:0]  count_reg;
    logic [3:0]  count_next;

    assign rise     = s2_reg & ~prev_reg;
    assign at_limit = (cnt_reg == LIMIT);

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            s1_reg   <= io_in;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: a rise arms or re-arms, the window limit without a rise disarms.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise && at_limit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM output logic: decode which datapath action happens this cycle.
    // A rise on the very last cycle of the window still counts as a measurement.
    always_comb begin
        do_arm     = 1'b0;
        do_measure = 1'b0;
        do_timeout = 1'b0;
        case (state_reg)
            IDLE: begin
                do_arm = rise;
            end
            MEASURE: begin
                do_measure = rise;
                do_timeout = !rise && at_limit;
            end
            default: begin
                do_arm = 1'b0;
            end
        endcase
    end

    // Datapath next values: counter, captured period, strobe, sticky timeout, LED count.
    always_comb begin
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        valid_next   = 1'b0;
        timeout_next = timeout_reg;
        count_next   = count_reg;
        if (do_arm) begin
            cnt_next = 32'd0;
        end else if (do_measure) begin
            cnt_next     = 32'd0;
            period_next  = cnt_reg + 32'd1;
            valid_next   = 1'b1;
            timeout_next = 1'b0;
            count_next   = count_reg + 4'd1;
        end else if (do_timeout) begin
            cnt_next     = 32'd0;
            timeout_next = 1'b1;
        end else if (state_reg == MEASURE) begin
            cnt_next = cnt_reg + 32'd1;
        end
    end

    // Datapath registers; reset discards any partial count.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_reg     <= 32'd0;
            period_reg  <= 32'd0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            count_reg   <= 4'd0;
        end else begin
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            count_reg   <= count_next;
        end
    end

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign timeout      = timeout_reg;
    assign io_out       = count_reg;

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed testbench for edge_period_meter with TIMEOUT_CYCLES = 100.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
`timescale 1ns/1ps

module tb_edge_period_meter;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        io_in = 1'b0;
    logic [31:0] period;
    logic        period_valid;
    logic        timeout;
    logic [3:0]  io_out;

    int total = 0;
    int bad = 0;

    edge_period_meter #(
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .io_in       (io_in),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .io_out      (io_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v);
        io_in = v;
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({period, period_valid, timeout, io_out} !== 38'd0) begin
            bad++;
            $display("FAIL reset_async: got period=%0d valid=%0b timeout=%0b io_out=%0d want all 0",
                     period, period_valid, timeout, io_out);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0);
            total++;
            if ({period, period_valid, timeout, io_out} !== 38'd0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got period=%0d valid=%0b timeout=%0b io_out=%0d want all 0",
                         k, period, period_valid, timeout, io_out);
            end
        end
        $display("reset: outputs cleared and held for 20 cycles");
    endtask

    task automatic test_steady();
        logic       exp_valid;
        int         exp_cnt;
        logic [31:0] exp_period;
        exp_cnt = 0;
        exp_period = 0;
        for (int i = 0; i < 50; i++) begin
            drive((i % 10) < 5);
            exp_valid = (i >= 12) && ((i - 2) % 10 == 0);
            if (exp_valid) begin
                exp_cnt++;
                exp_period = 32'd10;
            end
            total++;
            if (period_valid !== exp_valid) begin
                bad++;
                $display("FAIL steady_valid[%0d]: got %0b want %0b", i, period_valid, exp_valid);
            end
            total++;
            if (period !== exp_period || io_out !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL steady_value[%0d]: got period=%0d io_out=%0d want period=%0d io_out=%0d",
                         i, period, io_out, exp_period, exp_cnt);
            end
            if (exp_valid) begin
                $display("steady: cycle %0d period=%0d io_out=%0d", i, period, io_out);
            end
        end
    endtask

    task automatic test_timeout();
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        total++;
        if (period_valid !== 1'b1 || period !== 32'd10 || io_out !== 4'd5) begin
            bad++;
            $display("FAIL timeout_pre: got valid=%0b period=%0d io_out=%0d want 1 10 5",
                     period_valid, period, io_out);
        end
        for (int k = 1; k <= 105; k++) begin
            drive(1'b0);
            total++;
            if (timeout !== (k >= 100) || period_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: got timeout=%0b valid=%0b want %0b 0",
                         k, timeout, period_valid, k >= 100);
            end
        end
        total++;
        if (period !== 32'd10) begin
            bad++;
            $display("FAIL timeout_hold: got period=%0d want 10", period);
        end
        drive(1'b1);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0);
            total++;
            if (period_valid !== 1'b0 || timeout !== 1'b1) begin
                bad++;
                $display("FAIL timeout_rearm[%0d]: got valid=%0b timeout=%0b want 0 1",
                         k, period_valid, timeout);
            end
        end
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        total++;
        if (period_valid !== 1'b1 || period !== 32'd7 || timeout !== 1'b0 || io_out !== 4'd6) begin
            bad++;
            $display("FAIL timeout_recover: got valid=%0b period=%0d timeout=%0b io_out=%0d want 1 7 0 6",
                     period_valid, period, timeout, io_out);
        end
        $display("timeout: flag after 100 cycles, recovered with period=%0d", period);
    endtask

    task automatic test_boundary();
        drive(1'b1);
        for (int k = 1; k <= 99; k++) begin
            drive(1'b0);
            total++;
            if (period_valid !== (k == 2) || timeout !== 1'b0) begin
                bad++;
                $display("FAIL bound_wait[%0d]: got valid=%0b timeout=%0b want %0b 0",
                         k, period_valid, timeout, k == 2);
            end
            if (k == 2) begin
                total++;
                if (period !== 32'd3 || io_out !== 4'd7) begin
                    bad++;
                    $display("FAIL bound_short: got period=%0d io_out=%0d want 3 7", period, io_out);
                end
            end
        end
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        total++;
        if (period_valid !== 1'b1 || period !== 32'd100 || timeout !== 1'b0 || io_out !== 4'd8) begin
            bad++;
            $display("FAIL bound_100: got valid=%0b period=%0d timeout=%0b io_out=%0d want 1 100 0 8",
                     period_valid, period, timeout, io_out);
        end
        for (int k = 3; k <= 100; k++) begin
            drive(1'b0);
            total++;
            if (timeout !== 1'b0 || period_valid !== 1'b0) begin
                bad++;
                $display("FAIL bound_gap[%0d]: got timeout=%0b valid=%0b want 0 0", k, timeout, period_valid);
            end
        end
        drive(1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0);
            total++;
            if (timeout !== 1'b1 || period_valid !== 1'b0 || period !== 32'd100) begin
                bad++;
                $display("FAIL bound_101[%0d]: got timeout=%0b valid=%0b period=%0d want 1 0 100",
                         k, timeout, period_valid, period);
            end
        end
        $display("boundary: 100 measured, 101 timed out");
    endtask

    task automatic test_reset_mid();
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        total++;
        if (period_valid !== 1'b1 || period !== 32'd5 || io_out !== 4'd9 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: got valid=%0b period=%0d io_out=%0d timeout=%0b want 1 5 9 0",
                     period_valid, period, io_out, timeout);
        end
        drive(1'b0);
        drive(1'b0);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({period, period_valid, timeout, io_out} !== 38'd0) begin
            bad++;
            $display("FAIL mid_async: got period=%0d valid=%0b timeout=%0b io_out=%0d want all 0",
                     period, period_valid, timeout, io_out);
        end
        tick();
        rst = 1'b0;
        drive(1'b1);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0);
            total++;
            if (period_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_arm[%0d]: got valid=%0b want 0", k, period_valid);
            end
        end
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        total++;
        if (period_valid !== 1'b1 || period !== 32'd6 || io_out !== 4'd1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL mid_post: got valid=%0b period=%0d io_out=%0d timeout=%0b want 1 6 1 0",
                     period_valid, period, io_out, timeout);
        end
        $display("reset_mid: partial discarded, period=%0d io_out=%0d", period, io_out);
    endtask

    task automatic test_wrap();
        logic exp_valid;
        int   exp_cnt;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0);
        drive(1'b0);
        exp_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            drive((t % 2 == 0) && (t < 36));
            exp_valid = (t >= 4) && (t % 2 == 0) && (t <= 36);
            if (exp_valid) begin
                exp_cnt++;
            end
            total++;
            if (period_valid !== exp_valid) begin
                bad++;
                $display("FAIL wrap_valid[%0d]: got %0b want %0b", t, period_valid, exp_valid);
            end
            total++;
            if (period !== ((t >= 4) ? 32'd2 : 32'd0) || io_out !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL wrap_value[%0d]: got period=%0d io_out=%0d want period=%0d io_out=%0d",
                         t, period, io_out, (t >= 4) ? 2 : 0, exp_cnt % 16);
            end
        end
        total++;
        if (io_out !== 4'd1 || exp_cnt != 17) begin
            bad++;
            $display("FAIL wrap_final: got io_out=%0d measurements=%0d want 1 17", io_out, exp_cnt);
        end
        $display("wrap: 17 measurements of period 2, io_out=%0d", io_out);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
